// File: rtl/reg_rename_file_if.sv
// Bus bundle for reg_rename_file: issue/commit/flush controls, flattened read ports and RoB query.
// master = surrounding pipeline (decoder/RoB/RS), slave = the register file itself.
interface reg_rename_file_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int NRD   = 2
);
  localparam int RW = $clog2(NREG);

  logic                 rdy;
  logic                 flush;
  logic [TAG_W-1:0]     issue_rob_id;
  logic [RW-1:0]        issue_rd;
  logic [TAG_W-1:0]     commit_rob_id;
  logic [RW-1:0]        commit_rd;
  logic [XLEN-1:0]      commit_value;
  logic [NRD*RW-1:0]    rd_addr;
  logic [NRD*TAG_W-1:0] ask_rob_id;
  logic [NRD*XLEN-1:0]  rob_value;
  logic [NRD-1:0]       rob_ready;
  logic [NRD*XLEN-1:0]  rd_value;
  logic [NRD-1:0]       rd_has_dep;
  logic [NRD*TAG_W-1:0] rd_dep_id;
  logic [RW:0]          dep_count;

  modport master (
    output rdy, flush, issue_rob_id, issue_rd, commit_rob_id, commit_rd, commit_value,
           rd_addr, rob_value, rob_ready,
    input  ask_rob_id, rd_value, rd_has_dep, rd_dep_id, dep_count
  );

  modport slave (
    input  rdy, flush, issue_rob_id, issue_rd, commit_rob_id, commit_rd, commit_value,
           rd_addr, rob_value, rob_ready,
    output ask_rob_id, rd_value, rd_has_dep, rd_dep_id, dep_count
  );
endinterface

// File: rtl/reg_rename_file.sv
// Architectural register file with rename-tag tracking, mispredict flush, hardwired x0 and a
// live-tag counter. Optional same-cycle commit forwarding is enabled by REGFILE_COMMIT_BYPASS_EN.
module reg_rename_file #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int NRD   = 2
) (
  input  logic             clk,
  input  logic             rst,
  reg_rename_file_if.slave bus
);
  localparam int RW = $clog2(NREG);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [RW:0]      cnt_q, cnt_d;

  logic             issue_v, commit_v, commit_match;
  logic             cnt_set, cnt_clr;
  logic [RW-1:0]    r_idx  [NRD];
  logic [NRD-1:0]   byp_hit;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first,
  // so no path through the block can leave a value held (which would infer a latch).
  always_comb begin
    issue_v      = (bus.issue_rob_id != '0) && (bus.issue_rd != '0);
    commit_v     = (bus.commit_rob_id != '0) && (bus.commit_rd != '0);
    commit_match = commit_v && busy_q[bus.commit_rd] &&
                   (tag_q[bus.commit_rd] == bus.commit_rob_id);
    // Re-issuing a busy register keeps it busy; an issue on the committing register wins over the clear.
    cnt_set      = issue_v && !busy_q[bus.issue_rd];
    cnt_clr      = commit_match && !(issue_v && (bus.issue_rd == bus.commit_rd));
  end

  always_comb begin
    regs_d = regs_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (bus.rdy) begin
      if (commit_v) begin
        regs_d[bus.commit_rd] = bus.commit_value;
        if (commit_match) begin
          busy_d[bus.commit_rd] = 1'b0;
          tag_d[bus.commit_rd]  = '0;
        end
      end
      if (bus.flush) begin
        busy_d = '0;
        for (int i = 0; i < NREG; i++) tag_d[i] = '0;
        cnt_d  = '0;
      end else begin
        if (issue_v) begin
          busy_d[bus.issue_rd] = 1'b1;
          tag_d[bus.issue_rd]  = bus.issue_rob_id;
        end
        cnt_d = cnt_q + {{RW{1'b0}}, cnt_set} - {{RW{1'b0}}, cnt_clr};
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<='; the register array is reset here too because
  // x0..xN must read as zero straight after reset, not whatever the storage powered up with.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read ports see the pre-issue mapping, so a same-cycle rename of the source is not visible.
  always_comb begin
    bus.ask_rob_id = '0;
    bus.rd_value   = '0;
    bus.rd_has_dep = '0;
    bus.rd_dep_id  = '0;
    byp_hit        = '0;
    for (int p = 0; p < NRD; p++) begin
      r_idx[p] = bus.rd_addr[p*RW +: RW];
`ifdef REGFILE_COMMIT_BYPASS_EN
      byp_hit[p] = (bus.commit_rd == r_idx[p]) && (bus.commit_rob_id == tag_q[r_idx[p]]);
`else
      byp_hit[p] = 1'b0;
`endif
      if (r_idx[p] == '0) begin
        bus.rd_value[p*XLEN +: XLEN] = '0;
      end else if (!busy_q[r_idx[p]]) begin
        bus.rd_value[p*XLEN +: XLEN] = regs_q[r_idx[p]];
      end else begin
        bus.ask_rob_id[p*TAG_W +: TAG_W] = tag_q[r_idx[p]];
        if (byp_hit[p]) begin
          bus.rd_value[p*XLEN +: XLEN] = bus.commit_value;
        end else if (bus.rob_ready[p]) begin
          bus.rd_value[p*XLEN +: XLEN] = bus.rob_value[p*XLEN +: XLEN];
        end else begin
          bus.rd_has_dep[p]               = 1'b1;
          bus.rd_dep_id[p*TAG_W +: TAG_W] = tag_q[r_idx[p]];
        end
      end
    end
  end

  assign bus.dep_count = cnt_q;

  cnt_matches_busy: assert property (@(posedge clk) disable iff (!rst)
    bus.dep_count == ($countones(busy_q) & {(RW+1){1'b1}}));

  x0_never_busy: assert property (@(posedge clk) disable iff (!rst) !busy_q[0]);
endmodule
